// File: rtl/sync_deserializer.sv
// Serial-to-parallel receiver: hunts for a sync word, verifies alignment, locks,
// strips periodic sync slots and delivers payload words through a show-ahead FIFO.
module sync_deserializer #(
  parameter int unsigned                DATA_WIDTH   = 4,
  parameter logic [DATA_WIDTH-1:0]      SYNC_PATTERN = DATA_WIDTH'(4'b1011),
  parameter int unsigned                LOCK_COUNT   = 2,
  parameter int unsigned                FRAME_WORDS  = 4,
  parameter int unsigned                MISS_LIMIT   = 2,
  parameter int unsigned                FIFO_DEPTH   = 4
) (
  input  logic                  fastClk,
  input  logic                  reset,
  input  logic                  dataIn,
  input  logic                  control,
  input  logic                  msbFirst,
  input  logic                  dataReady,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  output logic                  locked,
  output logic                  overflow
);

  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned WW = $clog2(FRAME_WORDS + 1);
  localparam int unsigned XW = $clog2(MISS_LIMIT + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] window;
  logic                  msb_q;
  logic [BW-1:0]         bit_cnt;
  logic [MW-1:0]         match_cnt;
  logic [WW-1:0]         word_cnt;
  logic [XW-1:0]         miss_cnt;

  logic [DATA_WIDTH-1:0] win_n;
  logic                  mode_flip;
  logic                  word_end;
  logic                  sync_hit;
  logic                  sync_slot;
  logic                  push;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  pop;
  logic                  full;
  logic                  wr_en;
  logic [PW-1:0]         rd_n;
  logic [CW-1:0]         count_n;
  logic [DATA_WIDTH-1:0] head_n;

  // Window shift and word-boundary decode for the bit arriving this cycle
  always_comb begin
    win_n     = msbFirst ? {window[DATA_WIDTH-2:0], dataIn}
                         : {dataIn, window[DATA_WIDTH-1:1]};
    mode_flip = (state != HUNT) && (msbFirst != msb_q);
    word_end  = (bit_cnt == BW'(DATA_WIDTH - 1));
    sync_hit  = (win_n == SYNC_PATTERN);
    sync_slot = (word_cnt == WW'(FRAME_WORDS));
    push      = control && !mode_flip && (state == LOCKED) && word_end && !sync_slot;
  end

  // Alignment FSM; everything freezes while control is low
  always_ff @(posedge fastClk or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      window    <= '0;
      msb_q     <= 1'b0;
      bit_cnt   <= '0;
      match_cnt <= '0;
      word_cnt  <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
    end else if (control) begin
      window <= win_n;
      msb_q  <= msbFirst;
      if (mode_flip) begin
        // A bit-order change invalidates alignment; FIFO contents are kept
        state     <= HUNT;
        bit_cnt   <= '0;
        match_cnt <= '0;
        word_cnt  <= '0;
        miss_cnt  <= '0;
        locked    <= 1'b0;
      end else begin
        case (state)
          HUNT: begin
            if (sync_hit) begin
              bit_cnt  <= '0;
              word_cnt <= '0;
              miss_cnt <= '0;
              if (LOCK_COUNT == 1) begin
                state     <= LOCKED;
                match_cnt <= '0;
                locked    <= 1'b1;
              end else begin
                state     <= VERIFY;
                match_cnt <= MW'(1);
              end
            end
          end
          VERIFY: begin
            bit_cnt <= word_end ? '0 : bit_cnt + BW'(1);
            if (word_end) begin
              if (!sync_hit) begin
                state     <= HUNT;
                match_cnt <= '0;
              end else if (match_cnt == MW'(LOCK_COUNT - 1)) begin
                state     <= LOCKED;
                match_cnt <= '0;
                word_cnt  <= '0;
                miss_cnt  <= '0;
                locked    <= 1'b1;
              end else begin
                match_cnt <= match_cnt + MW'(1);
              end
            end
          end
          LOCKED: begin
            bit_cnt <= word_end ? '0 : bit_cnt + BW'(1);
            if (word_end) begin
              if (!sync_slot) begin
                word_cnt <= word_cnt + WW'(1);
              end else begin
                word_cnt <= '0;
                if (sync_hit) begin
                  miss_cnt <= '0;
                end else if (miss_cnt == XW'(MISS_LIMIT - 1)) begin
                  state    <= HUNT;
                  miss_cnt <= '0;
                  locked   <= 1'b0;
                end else begin
                  miss_cnt <= miss_cnt + XW'(1);
                end
              end
            end
          end
          default: begin
            state   <= HUNT;
            bit_cnt <= '0;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

  // FIFO next-state; the head is precomputed so dataOut can be a register
  always_comb begin
    pop     = dataValid && dataReady;
    full    = (count == CW'(FIFO_DEPTH));
    wr_en   = push && (!full || pop);
    rd_n    = pop ? rd_ptr + PW'(1) : rd_ptr;
    count_n = count + CW'(wr_en) - CW'(pop);
    head_n  = '0;
    if (count_n != '0) begin
      head_n = (wr_en && (wr_ptr == rd_n)) ? win_n : mem[rd_n];
    end
  end

  always_ff @(posedge fastClk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      dataOut   <= '0;
      dataValid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr    <= rd_n;
      count     <= count_n;
      dataOut   <= head_n;
      dataValid <= (count_n != '0);
      if (push && !wr_en) begin
        overflow <= 1'b1;
      end
    end
  end

  // Storage array needs no reset: occupancy is tracked by count
  always_ff @(posedge fastClk) begin
    if (wr_en) begin
      mem[wr_ptr] <= win_n;
    end
  end

endmodule
